// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: waits for a stable PLL lock, releases subsystem resets
// one stage at a time, and asks the reset generator for a PLL reset when lock
// is lost or never shows up. Gives up (sticky Fault) after MAX_RETRY timeouts.
//
// state      | meaning
// -----------+------------------------------------------------------------
// WAIT_LOCK  | waiting for lk; timeout counter running
// STABLE     | lk seen; counting consecutive locked cycles
// RELEASE    | releasing Stage_RESETn bits LSB first, STAGE_GAP apart
// RUN        | all stages released, PLL locked, SysReady high
// PLLRST     | driving PllRstReq for REQ_LEN cycles; lk ignored
// FAULT      | retries exhausted; everything held until Ext_RESET
module pll_lock_supervisor #(
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned STAGE_GAP    = 8,
    parameter int unsigned REQ_LEN      = 15,
    parameter int unsigned LOCK_TIMEOUT = 12000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned NUM_STAGE    = 3
) (
    input  logic                 Ext_CLK,
    input  logic                 Ext_RESET,
    input  logic                 PllLocked,
    output logic                 PllRstReq,
    output logic [NUM_STAGE-1:0] Stage_RESETn,
    output logic                 SysReady,
    output logic                 Fault,
    output logic [1:0]           RetryCnt
);

    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned STB_W = $clog2(LOCK_STABLE) + 1;
    localparam int unsigned GAP_W = $clog2(STAGE_GAP) + 1;
    localparam int unsigned REQ_W = $clog2(REQ_LEN) + 1;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN,
        ST_PLLRST,
        ST_FAULT
    } state_t;

    state_t               state_q,   state_d;
    logic [TMO_W-1:0]     tmo_q,     tmo_d;
    logic [STB_W-1:0]     stb_q,     stb_d;
    logic [GAP_W-1:0]     gap_q,     gap_d;
    logic [REQ_W-1:0]     req_cnt_q, req_cnt_d;
    logic [NUM_STAGE-1:0] stage_q,   stage_d;
    logic                 req_q,     req_d;
    logic                 ready_q,   ready_d;
    logic                 fault_q,   fault_d;
    logic [1:0]           retry_q,   retry_d;

    logic                 lk_meta_q;
    logic                 lk_q;

    logic [TMO_W-1:0]     tmo_inc;
    logic [STB_W-1:0]     stb_inc;
    logic [GAP_W-1:0]     gap_inc;
    logic [NUM_STAGE-1:0] stage_next;

    assign tmo_inc    = tmo_q + TMO_W'(1);
    assign stb_inc    = stb_q + STB_W'(1);
    assign gap_inc    = gap_q + GAP_W'(1);
    assign stage_next = (stage_q << 1) | NUM_STAGE'(1);

    // Two-flop synchronizer for the PLL lock pin; left unreset so it keeps
    // tracking the pin straight through Ext_RESET.
    always_ff @(posedge Ext_CLK) begin
        lk_meta_q <= PllLocked;
        lk_q      <= lk_meta_q;
    end

    // State, counters and registered outputs, with synchronous reset.
    always_ff @(posedge Ext_CLK) begin
        if (Ext_RESET) begin
            state_q   <= ST_WAIT_LOCK;
            tmo_q     <= '0;
            stb_q     <= '0;
            gap_q     <= '0;
            req_cnt_q <= '0;
            stage_q   <= '0;
            req_q     <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            retry_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            stb_q     <= stb_d;
            gap_q     <= gap_d;
            req_cnt_q <= req_cnt_d;
            stage_q   <= stage_d;
            req_q     <= req_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            retry_q   <= retry_d;
        end
    end

    // Next-state and next-output logic; counters default to clear so each
    // one only survives while its own state keeps it going.
    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        stb_d     = '0;
        gap_d     = '0;
        req_cnt_d = '0;
        stage_d   = stage_q;
        req_d     = 1'b0;
        ready_d   = ready_q;
        fault_d   = fault_q;
        retry_d   = retry_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (lk_q) begin
                    state_d = ST_STABLE;
                    stb_d   = STB_W'(1);
                end else if (tmo_inc >= TMO_W'(LOCK_TIMEOUT)) begin
                    if (retry_q >= 2'(MAX_RETRY)) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        stage_d = '0;
                        ready_d = 1'b0;
                    end else begin
                        state_d   = ST_PLLRST;
                        retry_d   = retry_q + 2'd1;
                        req_d     = 1'b1;
                        req_cnt_d = REQ_W'(1);
                    end
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            ST_STABLE: begin
                if (!lk_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stb_inc >= STB_W'(LOCK_STABLE)) begin
                    state_d = ST_RELEASE;
                end else begin
                    stb_d = stb_inc;
                end
            end

            ST_RELEASE: begin
                // Lock loss is checked first so it wins over a last-stage release.
                if (!lk_q) begin
                    state_d   = ST_PLLRST;
                    stage_d   = '0;
                    ready_d   = 1'b0;
                    req_d     = 1'b1;
                    req_cnt_d = REQ_W'(1);
                end else if (gap_inc >= GAP_W'(STAGE_GAP)) begin
                    stage_d = stage_next;
                    if (stage_next == {NUM_STAGE{1'b1}}) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                        retry_d = 2'd0;
                    end
                end else begin
                    gap_d = gap_inc;
                end
            end

            ST_RUN: begin
                if (!lk_q) begin
                    state_d   = ST_PLLRST;
                    stage_d   = '0;
                    ready_d   = 1'b0;
                    req_d     = 1'b1;
                    req_cnt_d = REQ_W'(1);
                end
            end

            ST_PLLRST: begin
                // req_cnt_q holds how many request cycles have already been driven.
                if (req_cnt_q >= REQ_W'(REQ_LEN)) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    req_d     = 1'b1;
                    req_cnt_d = req_cnt_q + REQ_W'(1);
                end
            end

            ST_FAULT: begin
                fault_d = 1'b1;
                stage_d = '0;
                ready_d = 1'b0;
            end

            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    assign PllRstReq    = req_q;
    assign Stage_RESETn = stage_q;
    assign SysReady     = ready_q;
    assign Fault        = fault_q;
    assign RetryCnt     = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor. Every output change is predicted as
// {edge number, output vector} and pushed to a queue ahead of time; a monitor
// on the falling edge pops and compares each change it sees.
module tb_pll_lock_supervisor;

    localparam int unsigned LOCK_TIMEOUT = 12000;

    logic       clk = 1'b0;
    logic       Ext_RESET;
    logic       PllLocked;
    logic       PllRstReq;
    logic [2:0] Stage_RESETn;
    logic       SysReady;
    logic       Fault;
    logic [1:0] RetryCnt;

    pll_lock_supervisor dut (
        .Ext_CLK      (clk),
        .Ext_RESET    (Ext_RESET),
        .PllLocked    (PllLocked),
        .PllRstReq    (PllRstReq),
        .Stage_RESETn (Stage_RESETn),
        .SysReady     (SysReady),
        .Fault        (Fault),
        .RetryCnt     (RetryCnt)
    );

    always #5 clk = ~clk;

    // Edge counter: value N means the N-th rising edge has happened.
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cur  = 8'h00;
    logic [7:0] prev = 8'h00;
    logic [7:0] obs;
    exp_t       e;
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // vector = {Stage_RESETn[2:0], SysReady, PllRstReq, Fault, RetryCnt[1:0]}
    function automatic logic [7:0] mk(input logic [2:0] st, input logic rdy,
                                      input logic req, input logic flt,
                                      input logic [1:0] rc);
        return {st, rdy, req, flt, rc};
    endfunction

    task automatic expect_at(input int c, input logic [7:0] v);
        if (v !== cur) begin
            exp_q.push_back('{cyc: c, vec: v});
            cur = v;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        expect_at(cyc + 1, 8'h00);
        Ext_RESET = 1'b1;
        tick(1);
        Ext_RESET = 1'b0;
    endtask

    // Output-change monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (mon_en) begin
            obs = {Stage_RESETn, SysReady, PllRstReq, Fault, RetryCnt};
            if (obs !== prev) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = '{cyc: -1, vec: prev};
                checks++;
                assert (cyc == e.cyc && obs === e.vec)
                else begin
                    errors++;
                    $error("FAIL change: edge %0d vec %b, expected edge %0d vec %b",
                           cyc, obs, e.cyc, e.vec);
                end
                prev = obs;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                assert (prev === e.vec)
                else begin
                    errors++;
                    $error("FAIL missed: at edge %0d vec %b, expected edge %0d vec %b",
                           cyc, prev, e.cyc, e.vec);
                end
            end
        end
    end

    int p;
    int c;
    int t;

    initial begin
        Ext_RESET = 1'b1;
        PllLocked = 1'b0;
        tick(3);

        // Reset values
        checks++;
        assert (Stage_RESETn === 3'b000) else begin
            errors++; $error("FAIL rst_stage: got %b expected 000", Stage_RESETn);
        end
        checks++;
        assert (PllRstReq === 1'b0) else begin
            errors++; $error("FAIL rst_req: got %b expected 0", PllRstReq);
        end
        checks++;
        assert (SysReady === 1'b0) else begin
            errors++; $error("FAIL rst_ready: got %b expected 0", SysReady);
        end
        checks++;
        assert (Fault === 1'b0) else begin
            errors++; $error("FAIL rst_fault: got %b expected 0", Fault);
        end
        checks++;
        assert (RetryCnt === 2'd0) else begin
            errors++; $error("FAIL rst_retry: got %0d expected 0", RetryCnt);
        end

        Ext_RESET = 1'b0;
        cur    = 8'h00;
        prev   = 8'h00;
        mon_en = 1'b1;

        // Clean lock: pin up at reset+10 -> releases at +36, +44, +52
        tick(10);
        p = cyc;
        PllLocked = 1'b1;
        expect_at(p + 26, mk(3'b001, 0, 0, 0, 2'd0));
        expect_at(p + 34, mk(3'b011, 0, 0, 0, 2'd0));
        expect_at(p + 42, mk(3'b111, 1, 0, 0, 2'd0));
        tick(50);

        // Lock loss in RUN, then relock
        p = cyc;
        PllLocked = 1'b0;
        expect_at(p + 3,  mk(3'b000, 0, 1, 0, 2'd0));
        expect_at(p + 18, mk(3'b000, 0, 0, 0, 2'd0));
        tick(20);
        p = cyc;
        PllLocked = 1'b1;
        expect_at(p + 26, mk(3'b001, 0, 0, 0, 2'd0));
        expect_at(p + 34, mk(3'b011, 0, 0, 0, 2'd0));
        expect_at(p + 42, mk(3'b111, 1, 0, 0, 2'd0));
        tick(50);

        // Glitch in STABLE: release 24 cycles after the final lk rise
        PllLocked = 1'b0;
        reset_pulse();
        tick(5);
        p = cyc;
        expect_at(p + 39, mk(3'b001, 0, 0, 0, 2'd0));
        expect_at(p + 47, mk(3'b011, 0, 0, 0, 2'd0));
        expect_at(p + 55, mk(3'b111, 1, 0, 0, 2'd0));
        PllLocked = 1'b1;
        tick(10);
        PllLocked = 1'b0;
        tick(3);
        PllLocked = 1'b1;
        tick(60);

        // Reset mid-RELEASE with the pin held high
        c = cyc;
        reset_pulse();
        expect_at(c + 25, mk(3'b001, 0, 0, 0, 2'd0));
        tick(24);
        reset_pulse();
        expect_at(c + 50, mk(3'b001, 0, 0, 0, 2'd0));
        expect_at(c + 58, mk(3'b011, 0, 0, 0, 2'd0));
        expect_at(c + 66, mk(3'b111, 1, 0, 0, 2'd0));
        tick(54);

        // lk falls on the last-release edge: lock loss wins
        c = cyc;
        reset_pulse();
        expect_at(c + 25, mk(3'b001, 0, 0, 0, 2'd0));
        expect_at(c + 33, mk(3'b011, 0, 0, 0, 2'd0));
        expect_at(c + 41, mk(3'b000, 0, 1, 0, 2'd0));
        expect_at(c + 56, mk(3'b000, 0, 0, 0, 2'd0));
        tick(37);
        PllLocked = 1'b0;
        tick(30);

        // No lock ever: three retries then Fault
        reset_pulse();
        t = cyc + LOCK_TIMEOUT;
        expect_at(t,      mk(3'b000, 0, 1, 0, 2'd1));
        expect_at(t + 15, mk(3'b000, 0, 0, 0, 2'd1));
        t = t + 15 + LOCK_TIMEOUT;
        expect_at(t,      mk(3'b000, 0, 1, 0, 2'd2));
        expect_at(t + 15, mk(3'b000, 0, 0, 0, 2'd2));
        t = t + 15 + LOCK_TIMEOUT;
        expect_at(t,      mk(3'b000, 0, 1, 0, 2'd3));
        expect_at(t + 15, mk(3'b000, 0, 0, 0, 2'd3));
        t = t + 15 + LOCK_TIMEOUT;
        expect_at(t,      mk(3'b000, 0, 0, 1, 2'd3));
        tick(t + 5 - cyc);

        // Lock after Fault changes nothing
        PllLocked = 1'b1;
        tick(100);
        checks++;
        assert (Fault === 1'b1) else begin
            errors++; $error("FAIL fault_sticky: got %b expected 1", Fault);
        end
        checks++;
        assert (Stage_RESETn === 3'b000 && SysReady === 1'b0) else begin
            errors++; $error("FAIL fault_hold: stage %b ready %b expected 000 0",
                             Stage_RESETn, SysReady);
        end

        reset_pulse();
        tick(5);
        checks++;
        assert (Fault === 1'b0 && RetryCnt === 2'd0) else begin
            errors++; $error("FAIL fault_clear: fault %b retry %0d expected 0 0",
                             Fault, RetryCnt);
        end

        tick(2);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++; $error("FAIL leftover: %0d expected events pending, expected 0",
                             exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the PLL lock after power-up and releases the function-generator subsystem resets in a fixed order once the PLL is stable. It runs on the free-running board clock next to the reset generator. It is the consumer of that generator's PLL reset/lock handshake: it watches `PllLocked`, sequences per-subsystem resets, and requests a PLL reset when lock is lost or never arrives.

## Interface

Parameters:
- `LOCK_STABLE`, 16: consecutive synchronized-lock cycles required before release.
- `STAGE_GAP`, 8: cycles between successive stage releases (≥1).
- `REQ_LEN`, 15: length of a `PllRstReq` pulse, in cycles (≥1).
- `LOCK_TIMEOUT`, 12000: cycles without lock in WAIT_LOCK before a retry.
- `MAX_RETRY`, 3: timeout retries before fault (≤3).
- `NUM_STAGE`, 3: number of staged resets (1..8).

Ports:
- `Ext_CLK` in 1: board clock, free-running.
- `Ext_RESET` in 1: reset, **synchronous, active-high**. One clock; no other clock domains.
- `PllLocked` in 1: PLL lock, asynchronous to `Ext_CLK`.
- `PllRstReq` out 1: active-high PLL reset request to the reset generator.
- `Stage_RESETn` out NUM_STAGE: active-low subsystem resets. Bit 0 is released first.
- `SysReady` out 1: high while all stages are released and the PLL is locked.
- `Fault` out 1: sticky. Set when retries are exhausted.
- `RetryCnt` out 2: number of timeout retries used since the last RUN or reset.

## Operation

- `PllLocked` passes through a 2-FF synchronizer to give `lk`. All decisions use `lk`. All outputs are registered.
- Reset values:
  - State = WAIT_LOCK, all counters = 0.
  - `Stage_RESETn` = all 0.
  - `PllRstReq` = 0, `SysReady` = 0, `Fault` = 0, `RetryCnt` = 0.
- `Ext_RESET` takes priority over every state, including mid-sequence. It restores the reset values on the next edge.
- FSM states: WAIT_LOCK, STABLE, RELEASE, RUN, PLLRST, FAULT.
- **WAIT_LOCK**
  - `lk` = 1: go to STABLE with the stable counter at 1.
  - Otherwise the timeout counter increments.
  - On reaching LOCK_TIMEOUT with `RetryCnt` < MAX_RETRY: `RetryCnt`++ and go to PLLRST.
  - On reaching LOCK_TIMEOUT with `RetryCnt` = MAX_RETRY: go to FAULT.
  - The timeout counter clears whenever the state is left.
- **STABLE**
  - `lk` = 0: return to WAIT_LOCK. The stable counter clears and no request is issued.
  - Stable counter = LOCK_STABLE: go to RELEASE with the gap counter cleared.
- **RELEASE**
  - The gap counter counts 1..STAGE_GAP. On reaching STAGE_GAP, the next `Stage_RESETn` bit (LSB first) goes to 1 and the counter clears.
  - On the edge that releases the last bit: enter RUN, and `SysReady` goes to 1 on that same edge.
  - Released bits stay at 1 until a lock loss or reset.
- **RUN**
  - `RetryCnt` clears on entry.
  - Holds while `lk` = 1.
- **Lock loss** (`lk` = 0 in RELEASE or RUN) on one edge:
  - `Stage_RESETn` = all 0, `SysReady` = 0, `PllRstReq` = 1.
  - Go to PLLRST. `RetryCnt` is not incremented.
- **PLLRST**
  - `PllRstReq` = 1 for exactly REQ_LEN cycles, then 0.
  - Then go to WAIT_LOCK. `lk` is ignored during this state.
- **FAULT**
  - `Fault` = 1, all stages held in reset, `PllRstReq` = 0.
  - Exit only via `Ext_RESET`.
- Counter widths are sized by `$clog2` of their parameter +1. No counter wraps; each clears on state change.

## Timing

- `PllLocked` rise to first `lk` = 1: 2 cycles.
- `lk` rise to `Stage_RESETn[0]` = 1: LOCK_STABLE + STAGE_GAP cycles, provided there is no dropout.
- Bit k is released STAGE_GAP·k cycles after bit 0.
- `lk` fall in RELEASE/RUN to all stages = 0: 1 cycle. End to end from the `PllLocked` pin: 3 cycles.
- `PllRstReq` is a single contiguous REQ_LEN-cycle pulse per entry into PLLRST. Pulses never merge.
- A lock glitch shorter than 2 cycles may or may not be seen. Any `lk` = 0 cycle in STABLE restarts the stable count.
- If `lk` falls on the same edge that releases the last stage, lock loss wins: enter PLLRST, `SysReady` stays 0.

## Test plan

- **Clean lock.** Reset, then `PllLocked` = 1 at cycle 10 → `Stage_RESETn` goes 001, 011, 111 at cycles 36, 44, 52; `SysReady` = 1 at cycle 52; `PllRstReq` never asserts.
- **Glitch in STABLE.** `PllLocked` high, then low for 3 cycles after 10 cycles → stable count restarts; release occurs 16+8 cycles after the final rise; no request pulse.
- **Lock loss in RUN.** Drop `PllLocked` → all stages = 0 and `SysReady` = 0 three cycles after the pin falls; `PllRstReq` high for exactly 15 cycles; relock re-runs the full sequence; `RetryCnt` = 0.
- **No lock ever.** → `PllRstReq` pulses at timeouts 1, 2, 3 with `RetryCnt` = 1, 2, 3; the 4th timeout sets `Fault` = 1; later `PllLocked` = 1 has no effect until `Ext_RESET`.
- **Reset mid-RELEASE.** After bit 0 is released, assert `Ext_RESET` for 1 cycle → next edge gives all stages 0 and state WAIT_LOCK; the sequence restarts from LOCK_STABLE.
- **Boundary case.** `lk` falls on the last-release edge → PLLRST is entered, `SysReady` is never 1, and the request pulse is REQ_LEN cycles long.
